// File: rtl/opt_ccff_loader.sv
// ---------------------------------------------------------------------------
// opt_ccff_loader
//
// Configuration-chain controller for the DSP `opt` output-mux bank. Words from
// the bitstream streamer are serialised LSB-first onto the 105-flop ccff chain
// while config_enable gates the chain clock. An optional verify pass then
// recirculates the chain through itself (tail -> head) and compares a CRC-8 of
// the bits read from ccff_tail with a CRC-8 of the bits shifted in.
//
// Ports:
//   prog_clock     in   clock shared with the chain flops
//   prog_reset     in   asynchronous active-high reset
//   start          in   one-cycle load request, sampled only in IDLE
//   verify_en      in   sampled with start; 1 = run verify after LOAD
//   cfg_data       in   configuration word, bit 0 shifted first
//   cfg_valid      in   cfg_data is valid
//   cfg_ready      out  word accepted on this cycle when cfg_valid is also 1
//   config_enable  out  chain shifts on an edge where this is 1
//   ccff_head      out  serial data into the chain
//   ccff_tail      in   serial data out of the chain's last flop
//   busy           out  1 in LOAD and VERIFY
//   done           out  one-cycle pulse at the end of an operation
//   error          out  verify CRC mismatch, sticky until next accepted start
//
// Handshake: a word transfers on a rising edge where cfg_valid and cfg_ready
// are both 1. cfg_ready never depends on cfg_valid; cfg_data need only be
// stable while cfg_valid is 1.
// ---------------------------------------------------------------------------
module opt_ccff_loader #(
  parameter int CHAIN_LEN = 105,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic              prog_clock,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              config_enable,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BL_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] word_buf;
  logic [BL_W-1:0]   bits_left;
  logic [7:0]        crc_in;
  logic [7:0]        crc_out;
  logic              verify_lat;
  logic              error_q;

  logic              load_shift;
  logic              last_shift;
  logic              take_word;
  logic [7:0]        crc_out_next;

  // CRC-8, x^8+x^2+x+1, MSB-first register form, one bit per call.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // All outputs decode registered state; the only input-to-output path is
  // the deliberate tail -> head recirculation during VERIFY.
  always_comb begin
    load_shift    = (state == S_LOAD) && (bits_left != '0);
    last_shift    = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    // bits_left == 1 in LOAD always implies a shift this cycle, so the next
    // word can be taken on the same edge the last buffered bit leaves.
    cfg_ready     = (state == S_LOAD) && (bits_left <= BL_W'(1));
    take_word     = cfg_ready && cfg_valid;
    config_enable = load_shift || (state == S_VERIFY);
    if (load_shift) begin
      ccff_head = word_buf[0];
    end else if (state == S_VERIFY) begin
      ccff_head = ccff_tail;
    end else begin
      ccff_head = 1'b0;
    end
    busy          = (state == S_LOAD) || (state == S_VERIFY);
    done          = (state == S_DONE);
    error         = error_q;
    crc_out_next  = crc8_step(crc_out, ccff_tail);
  end

  always_ff @(posedge prog_clock or posedge prog_reset) begin
    if (prog_reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      word_buf   <= '0;
      bits_left  <= '0;
      crc_in     <= '0;
      crc_out    <= '0;
      verify_lat <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LOAD;
            bit_cnt    <= '0;
            word_buf   <= '0;
            bits_left  <= '0;
            crc_in     <= '0;
            crc_out    <= '0;
            verify_lat <= verify_en;
            error_q    <= 1'b0;
          end
        end

        S_LOAD: begin
          if (load_shift) begin
            word_buf <= word_buf >> 1;
            crc_in   <= crc8_step(crc_in, word_buf[0]);
            if (last_shift) begin
              // Any bits still buffered belong past the chain end: drop them.
              bits_left <= '0;
              bit_cnt   <= '0;
              state     <= verify_lat ? S_VERIFY : S_DONE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (take_word) begin
                word_buf  <= cfg_data;
                bits_left <= BL_W'(WORD_W);
              end else begin
                bits_left <= bits_left - BL_W'(1);
              end
            end
          end else if (take_word) begin
            word_buf  <= cfg_data;
            bits_left <= BL_W'(WORD_W);
          end
        end

        S_VERIFY: begin
          crc_out <= crc_out_next;
          if (last_shift) begin
            bit_cnt <= '0;
            state   <= S_DONE;
            // Decided on entry to DONE so the flag is valid alongside done.
            error_q <= (crc_in != crc_out_next);
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opt_ccff_loader.sv
module tb_opt_ccff_loader;

  logic       prog_clock;
  logic       prog_reset;
  logic       start;
  logic       verify_en;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       config_enable;
  logic       ccff_head;
  logic       ccff_tail;
  logic       busy;
  logic       done;
  logic       error;

  int total;
  int bad;

  // Chain model: chain[0] is the head flop, chain[104] drives ccff_tail.
  logic [104:0] chain;
  logic         tail_force;
  logic [7:0]   words[14];
  logic [104:0] exp_chain;

  // Per-operation observations filled in by do_op.
  int   en_cnt;
  int   max_run;
  int   first_en;
  int   last_en;
  int   gap_cycles;
  int   done_cyc;
  logic done_seen;
  logic err_at_done;

  opt_ccff_loader dut (
    .prog_clock    (prog_clock),
    .prog_reset    (prog_reset),
    .start         (start),
    .verify_en     (verify_en),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  // ---------------- clock / chain model ----------------
  initial prog_clock = 1'b0;
  always #5 prog_clock = ~prog_clock;

  assign ccff_tail = tail_force ? 1'b1 : chain[104];

  always @(posedge prog_clock) begin
    if (config_enable === 1'b1) chain <= {chain[103:0], ccff_head};
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  function automatic logic stream_bit(input int i);
    logic [7:0] w;
    w = words[i / 8];
    return w[i % 8];
  endfunction

  // Bit i of the word stream ends up (i) flops before the tail.
  task automatic build_exp();
    for (int i = 0; i < 105; i++) exp_chain[104 - i] = stream_bit(i);
  endtask

  // One complete operation from start to done (or to a mid-load reset).
  // gap: 0 = valid always high, else valid only on cycles divisible by gap.
  // start_at: cycle index for a stray start pulse (-1 = none).
  // reset_at: assert reset once this many shifts have happened (-1 = none).
  task automatic do_op(input logic vfy, input int gap, input int start_at,
                       input int reset_at, input logic stuck);
    int idx;
    int run;
    en_cnt = 0; max_run = 0; run = 0; first_en = -1; last_en = -1;
    gap_cycles = 0; done_cyc = -1; done_seen = 1'b0; err_at_done = 1'b0;
    idx = 0;
    tail_force = stuck;
    @(posedge prog_clock); #1;
    start = 1'b1; verify_en = vfy;
    @(posedge prog_clock); #1;
    start = 1'b0; verify_en = ~vfy; // later changes must have no effect
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (reset_at >= 0 && en_cnt == reset_at) begin
        #2 prog_reset = 1'b1;
        #1;
        total++;
        if (config_enable !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0 ||
            ccff_head !== 1'b0 || done !== 1'b0) begin
          bad++;
          $display("FAIL mid_reset_async: en=%b busy=%b rdy=%b head=%b done=%b want all 0",
                   config_enable, busy, cfg_ready, ccff_head, done);
        end
        cfg_valid = 1'b0;
        repeat (2) @(posedge prog_clock);
        #1 prog_reset = 1'b0;
        break;
      end
      if (done === 1'b1) begin
        done_seen = 1'b1; done_cyc = cyc; err_at_done = error;
        break;
      end
      if (config_enable === 1'b1) begin
        en_cnt++; run++;
        if (run > max_run) max_run = run;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end else begin
        run = 0;
        if (busy === 1'b1) gap_cycles++;
      end
      if (cyc == start_at) begin
        start = 1'b1; verify_en = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (idx < 14 && (gap == 0 || cyc % gap == 0)) begin
        cfg_valid = 1'b1; cfg_data = words[idx];
      end else begin
        cfg_valid = 1'b0;
      end
      if (cfg_valid && cfg_ready === 1'b1) idx++;
      @(posedge prog_clock); #1;
    end
    cfg_valid = 1'b0; start = 1'b0; verify_en = 1'b0;
    tail_force = 1'b0;
    if (reset_at < 0) begin
      total++;
      if (!done_seen) begin
        bad++;
        $display("FAIL op_timeout: done not seen within cycle budget, want done");
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    prog_reset = 1'b1;
    #12;
    total++;
    if ({cfg_ready, config_enable, ccff_head, busy, done, error} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 000000",
               {cfg_ready, config_enable, ccff_head, busy, done, error});
    end
    @(posedge prog_clock); #1 prog_reset = 1'b0;
    cfg_valid = 1'b1; cfg_data = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      @(posedge prog_clock); #1;
      total++;
      if (cfg_ready !== 1'b0 || busy !== 1'b0 || config_enable !== 1'b0) begin
        bad++;
        $display("FAIL idle_ignores_valid: rdy=%b busy=%b en=%b want 0 0 0",
                 cfg_ready, busy, config_enable);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 14; i++) words[i] = 8'(i);
    build_exp();
    do_op(1'b0, 0, -1, -1, 1'b0);
    total++;
    if (en_cnt != 105 || max_run != 105) begin
      bad++;
      $display("FAIL stream_enable: count=%0d run=%0d want 105 105", en_cnt, max_run);
    end
    total++;
    if (first_en != 1 || done_cyc != 106) begin
      bad++;
      $display("FAIL stream_timing: first_en=%0d done_cyc=%0d want 1 106", first_en, done_cyc);
    end
    total++;
    if (err_at_done !== 1'b0) begin
      bad++;
      $display("FAIL stream_error: got %b want 0", err_at_done);
    end
    total++;
    if (chain !== exp_chain) begin
      bad++;
      $display("FAIL stream_chain: got %h want %h", chain, exp_chain);
    end
    @(posedge prog_clock); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || config_enable !== 1'b0) begin
      bad++;
      $display("FAIL stream_done_pulse: done=%b busy=%b en=%b want 0 0 0", done, busy, config_enable);
    end
  endtask

  task automatic test_bubble();
    chain = '0;
    for (int i = 0; i < 14; i++) words[i] = 8'(i);
    build_exp();
    do_op(1'b0, 11, -1, -1, 1'b0);
    total++;
    if (en_cnt != 105 || gap_cycles == 0 || max_run >= 105) begin
      bad++;
      $display("FAIL bubble_enable: count=%0d gaps=%0d run=%0d want 105 >0 <105",
               en_cnt, gap_cycles, max_run);
    end
    total++;
    if (done_cyc != last_en + 1) begin
      bad++;
      $display("FAIL bubble_done: done_cyc=%0d want %0d", done_cyc, last_en + 1);
    end
    total++;
    if (chain !== exp_chain) begin
      bad++;
      $display("FAIL bubble_chain: got %h want %h", chain, exp_chain);
    end
  endtask

  task automatic test_verify_pass();
    for (int i = 0; i < 14; i++) words[i] = 8'($urandom_range(0, 255));
    build_exp();
    do_op(1'b1, 0, -1, -1, 1'b0);
    total++;
    if (en_cnt != 210 || max_run != 210) begin
      bad++;
      $display("FAIL verify_enable: count=%0d run=%0d want 210 210", en_cnt, max_run);
    end
    total++;
    if (done_cyc != 211) begin
      bad++;
      $display("FAIL verify_done: done_cyc=%0d want 211", done_cyc);
    end
    total++;
    if (err_at_done !== 1'b0) begin
      bad++;
      $display("FAIL verify_error: got %b want 0", err_at_done);
    end
    total++;
    if (chain !== exp_chain) begin
      bad++;
      $display("FAIL verify_chain: got %h want %h", chain, exp_chain);
    end
  endtask

  task automatic test_verify_fail();
    logic [7:0] c_in;
    logic [7:0] c_ones;
    logic       exp_err;
    for (int i = 0; i < 14; i++) words[i] = 8'h3C ^ 8'(i * 17);
    c_in = '0; c_ones = '0;
    for (int i = 0; i < 105; i++) begin
      c_in   = crc_step(c_in, stream_bit(i));
      c_ones = crc_step(c_ones, 1'b1);
    end
    exp_err = (c_in != c_ones);
    do_op(1'b1, 0, -1, -1, 1'b1);
    total++;
    if (err_at_done !== exp_err) begin
      bad++;
      $display("FAIL verify_fail_error: got %b want %b", err_at_done, exp_err);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge prog_clock); #1;
      total++;
      if (error !== exp_err) begin
        bad++;
        $display("FAIL error_sticky: got %b want %b", error, exp_err);
      end
    end
    start = 1'b1; verify_en = 1'b0;
    @(posedge prog_clock); #1;
    start = 1'b0;
    total++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL error_clear_on_start: error=%b busy=%b want 0 1", error, busy);
    end
    // Abandon this load with a reset so the next test starts from IDLE.
    prog_reset = 1'b1;
    @(posedge prog_clock); #1 prog_reset = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic saw_done;
    for (int i = 0; i < 14; i++) words[i] = 8'hF0 - 8'(i);
    do_op(1'b0, 0, -1, 40, 1'b0);
    total++;
    if (en_cnt != 40) begin
      bad++;
      $display("FAIL mid_reset_shifts: got %0d want 40", en_cnt);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge prog_clock); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_no_done: got done/busy activity %b want 0", saw_done);
    end
    for (int i = 0; i < 14; i++) words[i] = 8'hA5 ^ 8'(i);
    build_exp();
    do_op(1'b0, 0, -1, -1, 1'b0);
    total++;
    if (en_cnt != 105 || chain !== exp_chain) begin
      bad++;
      $display("FAIL reload_chain: count=%0d got %h want 105 %h", en_cnt, chain, exp_chain);
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < 14; i++) words[i] = 8'h81 + 8'(i * 3);
    build_exp();
    do_op(1'b0, 0, 20, -1, 1'b0);
    total++;
    if (en_cnt != 105 || max_run != 105 || done_cyc != 106) begin
      bad++;
      $display("FAIL busy_start_ignored: count=%0d run=%0d done_cyc=%0d want 105 105 106",
               en_cnt, max_run, done_cyc);
    end
    total++;
    if (chain !== exp_chain) begin
      bad++;
      $display("FAIL busy_start_chain: got %h want %h", chain, exp_chain);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    total = 0; bad = 0;
    chain = '0; tail_force = 1'b0;
    start = 1'b0; verify_en = 1'b0; cfg_data = '0; cfg_valid = 1'b0;
    prog_reset = 1'b1;
    test_reset();
    test_stream();
    test_bubble();
    test_verify_pass();
    test_verify_fail();
    test_reset_mid_load();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
